// File: rtl/hydration_timer.sv
// Water-reminder timer: BCD time-of-day counter on a prescaled tick, with drink detection and a reminder FSM.
// Optional quiet-hours suppression is enabled by defining QUIET_HOURS_EN.
module hydration_timer #(
  parameter int CLK_HZ      = 50_000_000,
  parameter int RATE0       = 1,
  parameter int RATE1       = 60,
  parameter int RATE2       = 3600,
  parameter int REMIND_MIN  = 60,
  parameter int SNOOZE_MIN  = 10,
  parameter int DRINK_DELTA = 2,
  parameter int QUIET_START = 22,
  parameter int QUIET_END   = 7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  speed_sel,
  input  logic [3:0]  water_level,
  input  logic        ack,
  input  logic        time_load,
  input  logic [23:0] time_in,
  output logic [23:0] time_bcd,
  output logic        remind,
  output logic        load_err,
  output logic [7:0]  alert_cnt
);

  localparam int DIV0   = CLK_HZ / RATE0;
  localparam int DIV1   = CLK_HZ / RATE1;
  localparam int DIV2   = CLK_HZ / RATE2;
  localparam int DIVMX1 = (DIV0 > DIV1) ? DIV0 : DIV1;
  localparam int DIVMAX = (DIVMX1 > DIV2) ? DIVMX1 : DIV2;
  localparam int PW     = (DIVMAX > 1) ? $clog2(DIVMAX) : 1;
  localparam int MAXMIN = (REMIND_MIN > SNOOZE_MIN) ? REMIND_MIN : SNOOZE_MIN;
  localparam int CW     = $clog2(MAXMIN * 60 + 1);

  localparam logic [CW-1:0] REMIND_LD = CW'(REMIND_MIN * 60);
  localparam logic [CW-1:0] SNOOZE_LD = CW'(SNOOZE_MIN * 60);
  localparam logic [4:0]    QS        = 5'(QUIET_START);
  localparam logic [4:0]    QE        = 5'(QUIET_END);
  localparam logic [3:0]    DELTA     = 4'(DRINK_DELTA);

`ifdef QUIET_HOURS_EN
  localparam bit QUIET_EN = 1'b1;
`else
  localparam bit QUIET_EN = 1'b0;
`endif

  typedef enum logic [1:0] {ST_WAIT, ST_ALERT, ST_SNOOZE} state_t;

  state_t        r_state, w_nxt_state;
  logic [PW-1:0] r_presc, w_div_m1;
  logic [1:0]    r_speed;
  logic          r_init;
  logic          w_chg, w_tick;
  logic [23:0]   r_time, w_time_nxt;
  logic          w_load_ok;
  logic          r_load_err;
  logic [3:0]    r_prev;
  logic          w_drink;
  logic [CW-1:0] r_cnt, w_nxt_cnt;
  logic          w_alert_inc;
  logic [7:0]    r_alert_cnt;
  logic          r_remind;
  logic [4:0]    w_hour;
  logic          w_in_window, w_quiet;

  function automatic logic [23:0] bcd_inc(input logic [23:0] t);
    logic [3:0] h1, h0, m1, m0, s1, s0;
    {h1, h0, m1, m0, s1, s0} = t;
    if (s0 != 4'd9) s0 = s0 + 4'd1;
    else begin
      s0 = 4'd0;
      if (s1 != 4'd5) s1 = s1 + 4'd1;
      else begin
        s1 = 4'd0;
        if (m0 != 4'd9) m0 = m0 + 4'd1;
        else begin
          m0 = 4'd0;
          if (m1 != 4'd5) m1 = m1 + 4'd1;
          else begin
            m1 = 4'd0;
            if (h1 == 4'd2 && h0 == 4'd3) begin
              h1 = 4'd0;
              h0 = 4'd0;
            end else if (h0 == 4'd9) begin
              h0 = 4'd0;
              h1 = h1 + 4'd1;
            end else h0 = h0 + 4'd1;
          end
        end
      end
    end
    return {h1, h0, m1, m0, s1, s0};
  endfunction

  function automatic logic bcd_valid(input logic [23:0] t);
    logic [3:0] h1, h0, m1, m0, s1, s0;
    {h1, h0, m1, m0, s1, s0} = t;
    return (h1 <= 4'd2) && (h0 <= 4'd9) && !(h1 == 4'd2 && h0 > 4'd3) &&
           (m1 <= 4'd5) && (m0 <= 4'd9) && (s1 <= 4'd5) && (s0 <= 4'd9);
  endfunction

  // Prescaler: a speed change restarts the period so the first tick is a full period away
  always_comb begin
    case (speed_sel)
      2'd0:    w_div_m1 = PW'(DIV0 - 1);
      2'd1:    w_div_m1 = PW'(DIV1 - 1);
      2'd2:    w_div_m1 = PW'(DIV2 - 1);
      default: w_div_m1 = '0;
    endcase
  end

  assign w_chg  = (speed_sel != r_speed);
  assign w_tick = r_init && !w_chg && (speed_sel != 2'd3) && (r_presc == w_div_m1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_presc <= '0;
      r_speed <= 2'd0;
      r_init  <= 1'b0;
    end else begin
      r_init  <= 1'b1;
      r_speed <= speed_sel;
      if (!r_init || w_chg || speed_sel == 2'd3 || w_tick) r_presc <= '0;
      else r_presc <= r_presc + 1'b1;
    end
  end

  // Time of day: a load (accepted or rejected) takes precedence over the tick
  assign w_load_ok = bcd_valid(time_in);

  always_comb begin
    w_time_nxt = r_time;
    if (time_load) begin
      if (w_load_ok) w_time_nxt = time_in;
    end else if (w_tick) begin
      w_time_nxt = bcd_inc(r_time);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_time     <= 24'h000000;
      r_load_err <= 1'b0;
    end else begin
      r_time     <= w_time_nxt;
      r_load_err <= time_load && !w_load_ok;
    end
  end

  // Drink detection: prev_level is first captured on the clk after reset release
  assign w_drink = w_tick && (water_level < r_prev) && ((r_prev - water_level) >= DELTA);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_prev <= 4'd0;
    else if (!r_init || w_tick) r_prev <= water_level;
  end

  // Quiet window is judged on the hour the time is about to show
  assign w_hour = 5'({w_time_nxt[21:20], 3'b000}) + 5'({w_time_nxt[21:20], 1'b0}) +
                  5'(w_time_nxt[19:16]);

  always_comb begin
    if (QS > QE) w_in_window = (w_hour >= QS) || (w_hour < QE);
    else         w_in_window = (w_hour >= QS) && (w_hour < QE);
  end

  assign w_quiet = QUIET_EN && w_in_window;

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cnt   = r_cnt;
    w_alert_inc = 1'b0;
    if (w_drink) begin
      w_nxt_state = ST_WAIT;
      w_nxt_cnt   = REMIND_LD;
    end else begin
      case (r_state)
        ST_WAIT, ST_SNOOZE: begin
          if (w_tick) begin
            if (r_cnt <= CW'(1)) begin
              w_nxt_cnt = '0;
              if (!w_quiet) begin
                w_nxt_state = ST_ALERT;
                w_alert_inc = 1'b1;
              end
            end else begin
              w_nxt_cnt = r_cnt - CW'(1);
            end
          end
        end
        ST_ALERT: begin
          if (ack) begin
            w_nxt_state = ST_SNOOZE;
            w_nxt_cnt   = SNOOZE_LD;
          end
        end
        default: begin
          w_nxt_state = ST_WAIT;
          w_nxt_cnt   = REMIND_LD;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_WAIT;
      r_cnt       <= REMIND_LD;
      r_alert_cnt <= 8'd0;
      r_remind    <= 1'b0;
    end else begin
      r_state  <= w_nxt_state;
      r_cnt    <= w_nxt_cnt;
      r_remind <= (w_nxt_state == ST_ALERT) && !w_quiet;
      if (w_alert_inc && r_alert_cnt != 8'hFF) r_alert_cnt <= r_alert_cnt + 8'd1;
    end
  end

  assign time_bcd  = r_time;
  assign remind    = r_remind;
  assign load_err  = r_load_err;
  assign alert_cnt = r_alert_cnt;

endmodule

// File: tb/tb_hydration_timer.sv
// Directed bench for hydration_timer: two instances (long and short reminder intervals) at one tick per clk.
module tb_hydration_timer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic        a_rst = 1'b0, b_rst = 1'b0;
  logic [1:0]  a_spd, b_spd;
  logic [3:0]  a_lvl, b_lvl;
  logic        a_ack, b_ack, a_tl, b_tl;
  logic [23:0] a_tin, b_tin;
  logic [23:0] a_time, b_time;
  logic        a_remind, b_remind, a_lerr, b_lerr;
  logic [7:0]  a_acnt, b_acnt;

  hydration_timer #(.CLK_HZ(3600)) dut_a (
    .clk(clk), .reset(a_rst), .speed_sel(a_spd), .water_level(a_lvl), .ack(a_ack),
    .time_load(a_tl), .time_in(a_tin), .time_bcd(a_time), .remind(a_remind),
    .load_err(a_lerr), .alert_cnt(a_acnt)
  );

  hydration_timer #(.CLK_HZ(3600), .REMIND_MIN(1), .SNOOZE_MIN(1)) dut_b (
    .clk(clk), .reset(b_rst), .speed_sel(b_spd), .water_level(b_lvl), .ack(b_ack),
    .time_load(b_tl), .time_in(b_tin), .time_bcd(b_time), .remind(b_remind),
    .load_err(b_lerr), .alert_cnt(b_acnt)
  );

  typedef struct {
    logic [23:0] tin;
    logic        exp_err;
    logic [23:0] exp_time;
  } ld_vec_t;

  ld_vec_t vec [10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int highs;
    int waited;
    int k;

    vec[0] = '{24'h123456, 1'b0, 24'h123456};
    vec[1] = '{24'h246000, 1'b1, 24'h123456};
    vec[2] = '{24'h240000, 1'b1, 24'h123456};
    vec[3] = '{24'h196000, 1'b1, 24'h123456};
    vec[4] = '{24'h195960, 1'b1, 24'h123456};
    vec[5] = '{24'h00000A, 1'b1, 24'h123456};
    vec[6] = '{24'h0A0000, 1'b1, 24'h123456};
    vec[7] = '{24'h195959, 1'b0, 24'h195959};
    vec[8] = '{24'h000000, 1'b0, 24'h000000};
    vec[9] = '{24'h235958, 1'b0, 24'h235958};

    a_spd = 2'd2; b_spd = 2'd2;
    a_lvl = 4'd15; b_lvl = 4'd12;
    a_ack = 1'b0; b_ack = 1'b0; a_tl = 1'b0; b_tl = 1'b0;
    a_tin = 24'h0; b_tin = 24'h0;

    #1 a_rst = 1'b1; b_rst = 1'b1;
    #1;
    chk("reset_time", {8'h0, b_time}, 32'h0);
    chk("reset_remind", {31'h0, b_remind}, 32'h0);
    chk("reset_load_err", {31'h0, b_lerr}, 32'h0);
    chk("reset_alert_cnt", {24'h0, b_acnt}, 32'h0);

    // Short-interval instance: first reminder, snooze, drink handling
    @(negedge clk);
    b_rst = 1'b0;
    cyc(1);
    cyc(59);
    chk("b_remind_before_60", {31'h0, b_remind}, 32'h0);
    cyc(1);
    chk("b_remind_at_60", {31'h0, b_remind}, 32'h1);
    chk("b_alert_cnt_1", {24'h0, b_acnt}, 32'd1);
    chk("b_time_60s", {8'h0, b_time}, 32'h000100);

    b_ack = 1'b1;
    cyc(1);
    b_ack = 1'b0;
    chk("b_ack_clears", {31'h0, b_remind}, 32'h0);
    cyc(59);
    chk("b_snooze_before", {31'h0, b_remind}, 32'h0);
    cyc(1);
    chk("b_snooze_expiry", {31'h0, b_remind}, 32'h1);
    chk("b_alert_cnt_2", {24'h0, b_acnt}, 32'd2);

    b_lvl = 4'd9;
    cyc(1);
    b_lvl = 4'd12;
    chk("b_drink_clears", {31'h0, b_remind}, 32'h0);
    cyc(59);
    chk("b_drink_reload_before", {31'h0, b_remind}, 32'h0);
    cyc(1);
    chk("b_drink_reload_expiry", {31'h0, b_remind}, 32'h1);
    chk("b_alert_cnt_3", {24'h0, b_acnt}, 32'd3);

    b_lvl = 4'd11;
    cyc(1);
    chk("b_small_drop_ignored", {31'h0, b_remind}, 32'h1);
    chk("b_alert_cnt_still_3", {24'h0, b_acnt}, 32'd3);

    // Asynchronous reset in the middle of an alert
    b_rst = 1'b1;
    #1;
    chk("b_midreset_time", {8'h0, b_time}, 32'h0);
    chk("b_midreset_remind", {31'h0, b_remind}, 32'h0);
    chk("b_midreset_alert_cnt", {24'h0, b_acnt}, 32'h0);
    @(negedge clk);
    b_rst = 1'b0;
    b_lvl = 4'd12;
    cyc(1);
    cyc(30);
    chk("b_time_30s", {8'h0, b_time}, 32'h000030);

    b_spd = 2'd3;
    cyc(1000);
    chk("b_pause_time_frozen", {8'h0, b_time}, 32'h000030);
    chk("b_pause_no_remind", {31'h0, b_remind}, 32'h0);

    for (int i = 0; i < 10; i++) begin
      b_tin = vec[i].tin;
      b_tl  = 1'b1;
      cyc(1);
      b_tl  = 1'b0;
      chk($sformatf("load_err_v%0d", i), {31'h0, b_lerr}, {31'h0, vec[i].exp_err});
      chk($sformatf("load_time_v%0d", i), {8'h0, b_time}, {8'h0, vec[i].exp_time});
      cyc(1);
      chk($sformatf("load_err_drop_v%0d", i), {31'h0, b_lerr}, 32'h0);
    end

    b_spd = 2'd2;
    cyc(1);
    chk("b_resume_no_tick", {8'h0, b_time}, 32'h235958);
    cyc(1);
    chk("b_time_235959", {8'h0, b_time}, 32'h235959);
    cyc(1);
    chk("b_time_wrap", {8'h0, b_time}, 32'h000000);
    cyc(27);
    chk("b_countdown_frozen_before", {31'h0, b_remind}, 32'h0);
    cyc(1);
    chk("b_countdown_frozen_expiry", {31'h0, b_remind}, 32'h1);
    chk("b_alert_cnt_after_pause", {24'h0, b_acnt}, 32'd1);

`ifdef QUIET_HOURS_EN
    b_rst = 1'b1;
    @(negedge clk);
    b_rst = 1'b0;
    b_tin = 24'h215930;
    b_tl  = 1'b1;
    cyc(1);
    b_tl  = 1'b0;
    chk("q_load", {8'h0, b_time}, 32'h215930);
    highs = 0;
    for (int n = 1; n <= 32429; n++) begin
      cyc(1);
      if (b_remind) highs++;
    end
    chk("q_no_remind_in_window", highs, 0);
    chk("q_time_065959", {8'h0, b_time}, 32'h065959);
    cyc(1);
    chk("q_remind_at_0700", {31'h0, b_remind}, 32'h1);
    chk("q_time_070000", {8'h0, b_time}, 32'h070000);
`endif

    // Long-interval instance: full day with regular drinks
    a_rst = 1'b1;
    @(negedge clk);
    a_rst = 1'b0;
    a_lvl = 4'd15;
    cyc(1);
    chk("a_time_start", {8'h0, a_time}, 32'h0);
    highs = 0;
    for (int t = 1; t <= 86400; t++) begin
      if (t % 1800 == 0) begin
        k = (t / 1800) % 4;
        a_lvl = (k == 0) ? 4'd15 : 4'(15 - 4 * k);
      end
      cyc(1);
      if (a_remind) highs++;
      if (t == 86399) chk("a_time_235959", {8'h0, a_time}, 32'h235959);
      if (t == 86400) chk("a_time_day_wrap", {8'h0, a_time}, 32'h000000);
    end
    chk("a_no_remind_all_day", highs, 0);
    chk("a_alert_cnt_zero", {24'h0, a_acnt}, 32'h0);

    waited = 0;
    while (!a_remind && waited < 2000) begin
      cyc(1);
      waited++;
    end
    chk("a_expiry_ticks", waited, 1800);
    chk("a_alert_cnt_1", {24'h0, a_acnt}, 32'd1);

    a_lvl = 4'd10;
    a_ack = 1'b1;
    cyc(1);
    a_ack = 1'b0;
    chk("a_drink_ack_clears", {31'h0, a_remind}, 32'h0);
    cyc(700);
    chk("a_drink_beats_ack", {31'h0, a_remind}, 32'h0);
    chk("a_alert_cnt_held", {24'h0, a_acnt}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
